// File: rtl/score_argmax_tx.sv
// score_argmax_tx: sequential signed argmax over a vector of 8-bit class
// scores, followed by a framed result packet streamed byte-by-byte into a
// UART transmitter (tx_data / tx_enable / tx_busy handshake).
// Packet: 0xA5, class index, max score, scores 0..N_CLASSES-1 [, checksum].
// Optional feature macro: SCORE_PKT_CHECKSUM_EN appends the XOR of all
// preceding packet bytes as a final checksum byte.
module score_argmax_tx #(
    parameter int N_CLASSES = 10,
    parameter int IDX_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*N_CLASSES-1:0] scores_flat,
    input  logic                   scores_valid,
    output logic                   scores_ready,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_enable,
    output logic [IDX_W-1:0]       class_idx,
    output logic                   class_valid,
    output logic                   busy
);

`ifdef SCORE_PKT_CHECKSUM_EN
    localparam int PKT_LEN = N_CLASSES + 4;
`else
    localparam int PKT_LEN = N_CLASSES + 3;
`endif
    localparam int               PTR_W      = $clog2(PKT_LEN);
    localparam logic [7:0]       PKT_HEADER = 8'hA5;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CLASSES - 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(PKT_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [8*N_CLASSES-1:0] scores_r, scores_s;
    logic [IDX_W-1:0]       scan_idx_r, scan_idx_s;
    logic [IDX_W-1:0]       best_idx_r, best_idx_s;
    logic [7:0]             best_r, best_s;
    logic [PTR_W-1:0]       ptr_r, ptr_s;
    logic [7:0]             tx_data_r, tx_data_s;
    logic                   tx_enable_r, tx_enable_s;
    logic [IDX_W-1:0]       class_idx_r, class_idx_s;
    logic                   class_valid_r, class_valid_s;
    logic                   scores_ready_r;
    logic                   busy_r;
    logic [7:0]             cur_score_s;
    logic [7:0]             cur_byte_s;
    logic                   take_s;
`ifdef SCORE_PKT_CHECKSUM_EN
    logic [7:0]             chk_r, chk_s;

    // One step of the running XOR checksum.
    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
        chk_step = acc ^ b;
    endfunction
`endif

    // Extract score idx from a flat score vector.
    function automatic logic [7:0] score_at(input logic [8*N_CLASSES-1:0] vec, input int idx);
        score_at = vec[8*idx +: 8];
    endfunction

    // Current scan candidate and whether it replaces the running best
    // (index 0 always seeds; later ones only when strictly greater, so ties keep the lowest index).
    always_comb begin
        cur_score_s = score_at(scores_r, int'(scan_idx_r));
        take_s      = (scan_idx_r == IDX_W'(0)) || ($signed(cur_score_s) > $signed(best_r));
    end

    // Packet byte addressed by the byte pointer.
    always_comb begin
        cur_byte_s = 8'h00;
        if (ptr_r == PTR_W'(0)) begin
            cur_byte_s = PKT_HEADER;
        end else if (ptr_r == PTR_W'(1)) begin
            cur_byte_s = 8'(class_idx_r);
        end else if (ptr_r == PTR_W'(2)) begin
            cur_byte_s = best_r;
        end else if (int'(ptr_r) < N_CLASSES + 3) begin
            cur_byte_s = score_at(scores_r, int'(ptr_r) - 3);
        end else begin
`ifdef SCORE_PKT_CHECKSUM_EN
            cur_byte_s = chk_r;
`else
            cur_byte_s = 8'h00;
`endif
        end
    end

    // Next-state and next-output logic of the scan/transmit FSM.
    always_comb begin
        state_s       = state_r;
        scores_s      = scores_r;
        scan_idx_s    = scan_idx_r;
        best_s        = best_r;
        best_idx_s    = best_idx_r;
        ptr_s         = ptr_r;
        tx_data_s     = tx_data_r;
        tx_enable_s   = 1'b0;
        class_idx_s   = class_idx_r;
        class_valid_s = 1'b0;
`ifdef SCORE_PKT_CHECKSUM_EN
        chk_s         = chk_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (scores_valid && scores_ready_r) begin
                    scores_s   = scores_flat;
                    scan_idx_s = IDX_W'(0);
                    state_s    = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (take_s) begin
                    best_s     = cur_score_s;
                    best_idx_s = scan_idx_r;
                end else begin
                    best_s     = best_r;
                    best_idx_s = best_idx_r;
                end
                if (scan_idx_r == LAST_IDX) begin
                    class_idx_s   = take_s ? scan_idx_r : best_idx_r;
                    class_valid_s = 1'b1;
                    ptr_s         = PTR_W'(0);
`ifdef SCORE_PKT_CHECKSUM_EN
                    chk_s         = 8'h00;
`endif
                    state_s       = ST_SEND;
                end else begin
                    scan_idx_s = scan_idx_r + IDX_W'(1);
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_data_s   = cur_byte_s;
                    tx_enable_s = 1'b1;
`ifdef SCORE_PKT_CHECKSUM_EN
                    chk_s       = chk_step(chk_r, cur_byte_s);
`endif
                    state_s     = ST_WAIT_ACK;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_s = ST_WAIT_DONE;
                end else begin
                    state_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (ptr_r == LAST_PTR) begin
                        state_s = ST_IDLE;
                    end else begin
                        ptr_s   = ptr_r + PTR_W'(1);
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            scores_r       <= '0;
            scan_idx_r     <= IDX_W'(0);
            best_r         <= 8'h00;
            best_idx_r     <= IDX_W'(0);
            ptr_r          <= PTR_W'(0);
            tx_data_r      <= 8'h00;
            tx_enable_r    <= 1'b0;
            class_idx_r    <= IDX_W'(0);
            class_valid_r  <= 1'b0;
            scores_ready_r <= 1'b1;
            busy_r         <= 1'b0;
`ifdef SCORE_PKT_CHECKSUM_EN
            chk_r          <= 8'h00;
`endif
        end else begin
            state_r        <= state_s;
            scores_r       <= scores_s;
            scan_idx_r     <= scan_idx_s;
            best_r         <= best_s;
            best_idx_r     <= best_idx_s;
            ptr_r          <= ptr_s;
            tx_data_r      <= tx_data_s;
            tx_enable_r    <= tx_enable_s;
            class_idx_r    <= class_idx_s;
            class_valid_r  <= class_valid_s;
            scores_ready_r <= (state_s == ST_IDLE);
            busy_r         <= (state_s != ST_IDLE);
`ifdef SCORE_PKT_CHECKSUM_EN
            chk_r          <= chk_s;
`endif
        end
    end

    assign tx_data      = tx_data_r;
    assign tx_enable    = tx_enable_r;
    assign class_idx    = class_idx_r;
    assign class_valid  = class_valid_r;
    assign scores_ready = scores_ready_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_score_argmax_tx.sv
// Self-checking bench for score_argmax_tx: directed scenarios plus random
// vectors, checked against a packet model built from the argmax rules.
module tb_score_argmax_tx;
    localparam int NC = 10;
    localparam int IW = 4;
`ifdef SCORE_PKT_CHECKSUM_EN
    localparam int PLEN = NC + 4;
`else
    localparam int PLEN = NC + 3;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [8*NC-1:0] scores_flat;
    logic            scores_valid;
    logic            scores_ready;
    logic            tx_busy;
    logic [7:0]      tx_data;
    logic            tx_enable;
    logic [IW-1:0]   class_idx;
    logic            class_valid;
    logic            busy;

    int         tests = 0;
    int         fails = 0;
    int         proto_err = 0;
    logic [7:0] vec [NC];
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int         cv_q [$];
    int         exp_cv_q [$];
    bit         stall = 1'b0;
    bit         pend = 1'b0;
    int         busy_left = 0;
    logic       prev_en;

    score_argmax_tx #(.N_CLASSES(NC), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .scores_flat(scores_flat), .scores_valid(scores_valid),
        .scores_ready(scores_ready), .tx_busy(tx_busy), .tx_data(tx_data), .tx_enable(tx_enable),
        .class_idx(class_idx), .class_valid(class_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // UART model: tx_busy high for 5 cycles starting 1 cycle after each tx_enable; stall forces it high.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pend) begin
                pend = 1'b0;
                busy_left = 4;
                tx_busy = 1'b1;
            end else if (busy_left > 0) begin
                busy_left = busy_left - 1;
            end else begin
                tx_busy = stall;
            end
            if (tx_enable === 1'b1) pend = 1'b1;
        end
    end

    // Byte/strobe capture plus handshake protocol watch.
    initial begin
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (tx_enable === 1'b1) begin
                    rx_q.push_back(tx_data);
                    if (tx_busy === 1'b1 || prev_en === 1'b1) proto_err++;
                end
                if (class_valid === 1'b1) cv_q.push_back(int'(class_idx));
                if (busy === 1'b1 && scores_ready === 1'b1) proto_err++;
            end
            prev_en = tx_enable;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference packet: max of signed values, first index reaching it, then framing.
    task automatic model_packet();
        logic [7:0] pkt [$];
        logic [7:0] sum;
        int best_v;
        int idx;
        best_v = -129;
        idx = -1;
        for (int i = 0; i < NC; i++)
            if (int'($signed(vec[i])) > best_v) best_v = int'($signed(vec[i]));
        for (int i = 0; i < NC; i++)
            if (idx < 0 && int'($signed(vec[i])) == best_v) idx = i;
        pkt.push_back(8'hA5);
        pkt.push_back(8'(idx));
        pkt.push_back(8'(best_v));
        for (int i = 0; i < NC; i++) pkt.push_back(vec[i]);
`ifdef SCORE_PKT_CHECKSUM_EN
        sum = 8'h00;
        foreach (pkt[k]) sum = sum ^ pkt[k];
        pkt.push_back(sum);
`else
        sum = 8'h00;
`endif
        foreach (pkt[k]) exp_q.push_back(pkt[k]);
        exp_cv_q.push_back(idx);
    endtask

    task automatic load_flat();
        for (int i = 0; i < NC; i++) scores_flat[8*i +: 8] = vec[i];
    endtask

    task automatic present();
        @(negedge clk);
        load_flat();
        scores_valid = 1'b1;
        @(negedge clk);
        scores_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'(exp_q[i]));
        chk({tag, "_ncv"}, 32'(cv_q.size()), 32'(exp_cv_q.size()));
        for (int i = 0; i < exp_cv_q.size(); i++)
            chk($sformatf("%s_cls%0d", tag, i), (i < cv_q.size()) ? 32'(cv_q[i]) : 32'hDEAD, 32'(exp_cv_q[i]));
        chk({tag, "_txhold"}, 32'(tx_data), 32'(exp_q[exp_q.size()-1]));
        chk({tag, "_proto"}, 32'(proto_err), 32'd0);
        rx_q.delete();
        exp_q.delete();
        cv_q.delete();
        exp_cv_q.delete();
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        scores_valid = 1'b0;
        scores_flat = '0;

        // Reset with a vector offered: must be dropped.
        for (int i = 0; i < NC; i++) vec[i] = 8'(i + 1);
        load_flat();
        scores_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_enable", 32'(tx_enable), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_class_valid", 32'(class_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(scores_ready), 32'd1);
        rst_n = 1'b1;
        scores_valid = 1'b0;
        @(negedge clk);
        chk("rst_drop_busy", 32'(busy), 32'd0);
        chk("rst_drop_cv", 32'(cv_q.size()), 32'd0);

        // Single winner, with strobe/first-transmit latency.
        foreach (vec[i]) vec[i] = 8'h00;
        vec[3] = 8'h12;
        model_packet();
        present();
        repeat (NC - 1) @(negedge clk);
        chk("single_cv_early", 32'(class_valid), 32'd0);
        @(negedge clk);
        chk("single_cv", 32'(class_valid), 32'd1);
        chk("single_idx", 32'(class_idx), 32'd3);
        @(negedge clk);
        chk("single_first_en", 32'(tx_enable), 32'd1);
        chk("single_first_data", 32'(tx_data), 32'hA5);
        wait_idle("single");
        compare("single");

        // Negative scores.
        foreach (vec[i]) vec[i] = 8'h80;
        vec[7] = 8'hFF;
        model_packet();
        present();
        wait_idle("neg");
        compare("neg");

        // Tie goes to lowest index.
        foreach (vec[i]) vec[i] = 8'h00;
        vec[4] = 8'h40;
        vec[6] = 8'h40;
        model_packet();
        present();
        wait_idle("tie");
        compare("tie");

        // Second vector mid-packet is ignored.
        foreach (vec[i]) vec[i] = 8'($urandom_range(0, 255));
        model_packet();
        present();
        repeat (20) @(negedge clk);
        chk("busy_ready_low", 32'(scores_ready), 32'd0);
        for (int i = 0; i < NC; i++) scores_flat[8*i +: 8] = ~vec[i];
        scores_valid = 1'b1;
        repeat (5) @(negedge clk);
        scores_valid = 1'b0;
        wait_idle("ignore");
        compare("ignore");

        // Reset mid-packet after byte 5.
        foreach (vec[i]) vec[i] = 8'($urandom_range(0, 255));
        present();
        n = 0;
        while (rx_q.size() < 5 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_timeout", 32'(rx_q.size() >= 5), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx_enable", 32'(tx_enable), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_class_idx", 32'(class_idx), 32'd0);
        chk("midrst_ready", 32'(scores_ready), 32'd1);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        rx_q.delete();
        cv_q.delete();
        foreach (vec[i]) vec[i] = 8'($urandom_range(0, 255));
        model_packet();
        present();
        wait_idle("after_rst");
        compare("after_rst");

        // Transmitter stall at SEND entry.
        stall = 1'b1;
        foreach (vec[i]) vec[i] = 8'($urandom_range(0, 255));
        model_packet();
        present();
        repeat (NC + 100) @(negedge clk);
        chk("stall_no_tx", 32'(rx_q.size()), 32'd0);
        chk("stall_cv", 32'(cv_q.size()), 32'd1);
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_release_en", 32'(tx_enable), 32'd1);
        chk("stall_release_data", 32'(tx_data), 32'hA5);
        wait_idle("stall");
        compare("stall");

        // Back-to-back acceptance when scores_ready returns.
        foreach (vec[i]) vec[i] = 8'($urandom_range(0, 255));
        model_packet();
        model_packet();
        @(negedge clk);
        load_flat();
        scores_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (scores_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_ready_timeout", 32'(scores_ready), 32'd1);
        @(negedge clk);
        chk("b2b_accept", 32'(busy), 32'd1);
        scores_valid = 1'b0;
        wait_idle("b2b");
        compare("b2b");

        // Random vectors; even iterations use a tiny range to force ties.
        for (int r = 0; r < 6; r++) begin
            foreach (vec[i]) vec[i] = (r % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            model_packet();
            present();
            wait_idle($sformatf("rnd%0d", r));
            compare($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/score_argmax_tx.md
# score_argmax_tx

Downstream result stage for the layer-2 fully-connected output. Accepts the flat vector of signed 8-bit class scores, finds the winning class with a sequential argmax, and streams a framed result packet one byte at a time into the UART transmitter's `tx_data`/`tx_enable`/`tx_busy` interface. Replaces the raw 10-byte dump with a self-describing packet. Exposes the winning class index locally for LEDs or debug.

## Interface

Parameters:

- `N_CLASSES`, default 10: number of class scores.
- `IDX_W`, default 4: class index width. Must be at least clog2(`N_CLASSES`).

Ports:

- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: synchronous, active-low reset.
- `scores_flat`, in, 8*`N_CLASSES`: score *i* at bits [8i+7:8i], signed two's complement.
- `scores_valid`, in, 1: score vector present.
- `scores_ready`, out, 1: block can accept a vector.
- `tx_busy`, in, 1: UART transmitter busy.
- `tx_data`, out, 8: byte to transmit.
- `tx_enable`, out, 1: one-cycle transmit request.
- `class_idx`, out, `IDX_W`: winning class index.
- `class_valid`, out, 1: one-cycle strobe when `class_idx` updates.
- `busy`, out, 1: packet in progress (state is not IDLE).

## Operation

- **States:** IDLE, SCAN, SEND, WAIT_ACK, WAIT_DONE.
- **IDLE**
  - `scores_ready` = 1.
  - When `scores_valid` && `scores_ready`, latch `scores_flat`, clear the scan index, then go to SCAN.
- **SCAN**
  - One score is compared per cycle, index 0 to `N_CLASSES`-1.
  - The comparison is signed 8-bit. The running best is replaced only if the new score is strictly greater, so ties go to the lowest index.
  - Index 0 seeds the best unconditionally.
  - After the last index: load `class_idx`, pulse `class_valid`, clear the byte pointer, then go to SEND.
- **Packet**, in order:
  - 0xA5 header;
  - `class_idx`, zero-extended to 8 bits;
  - max score;
  - scores 0 to `N_CLASSES`-1;
  - optional checksum (see Configuration).
  - Length is `N_CLASSES`+3 bytes, 13 at the default.
- **SEND**
  - While `tx_busy`=1, hold state.
  - When `tx_busy`=0, drive `tx_data` with the current byte, assert `tx_enable` for exactly one cycle, then go to WAIT_ACK.
- **WAIT_ACK:** wait for `tx_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `tx_busy`=0, then do one of:
  - not the last byte: advance the byte pointer and return to SEND;
  - last byte: go to IDLE.
- **Input while not in IDLE:** `scores_valid` is ignored and the latched scores are unaffected.
- **Output hold:** `class_idx` holds its value until the next SCAN completes. `tx_data` holds its last value.

## Timing

- **Reset values:**
  - `tx_enable` = 0, `tx_data` = 0x00;
  - `class_idx` = 0, `class_valid` = 0;
  - `busy` = 0, state IDLE;
  - `scores_ready` = 1, but no vector is accepted while `rst_n` = 0.
- **Accept to strobe:** accept at cycle T; `class_valid` is high at T+`N_CLASSES`+1.
- **First transmit:** the first `tx_enable` is at T+`N_CLASSES`+2 at the earliest, with `tx_busy` low.
- **Gap between requests:** successive `tx_enable` pulses are separated by at least one full `tx_busy` high-to-low cycle. There is never a second request while `tx_busy` is high.
- **Simultaneous events:** accept and reset in the same cycle means reset wins, and the vector is dropped.
- **Reset mid-packet:** the packet is abandoned immediately and `tx_enable` is forced to 0. The next packet starts from the header.
- **Return to IDLE:** `scores_ready` rises the cycle after the final WAIT_DONE exit. A vector presented in that cycle is accepted back-to-back.

## Configuration

- **`SCORE_PKT_CHECKSUM_EN` defined:** one extra byte follows the scores. It is the XOR of all preceding packet bytes, header included. Packet length is `N_CLASSES`+4, 14 at the default.
- **`SCORE_PKT_CHECKSUM_EN` undefined:** no checksum logic. The packet ends after score `N_CLASSES`-1.

## Test plan

All scenarios use the default `N_CLASSES` = 10. The bench models `tx_busy` high for 5 cycles starting 1 cycle after each `tx_enable`, unless stated otherwise.

- **Single winner:** all scores 0x00 except score[3] = 0x12 ->
  - `class_valid` pulses with `class_idx` = 3;
  - bytes A5 03 12 00 00 00 12 00 00 00 00 00 00;
  - with the macro, a trailing A6.
- **Negative scores:** all scores 0x80 except score[7] = 0xFF -> `class_idx` = 7, byte 2 = 0xFF.
- **Tie:** score[4] = score[6] = 0x40, rest 0x00 -> `class_idx` = 4.
- **Input while busy:** a second `scores_valid` mid-packet with different scores -> ignored; the transmitted bytes match the first vector exactly; `scores_ready` = 0 throughout.
- **Reset mid-packet:** `rst_n` low for 1 cycle after byte 5 is sent ->
  - `tx_enable` = 0, `busy` = 0, `class_idx` = 0;
  - a new vector then produces a full packet starting with A5.
- **Transmitter stall:** hold `tx_busy` = 1 for 100 cycles at SEND entry -> no `tx_enable` is issued; the header goes out on the first cycle `tx_busy` = 0.
